// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/Synchronizer.sv
// Two-flop synchronizer bringing an asynchronous level into the clock domain.
// Latency: two clocks from input change to q.
// Backpressure: none; reset presets both flops to RESET_VAL (line idle).
module Synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw input, then re-register it to let metastability settle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start/data/stop detection into a one-entry output buffer.
// Latency: byte presented the cycle after the mid-stop-bit sample (~9.5 bit times after rx falls).
// Backpressure: valid/ready; a byte arriving while the buffer is held is dropped with an overrun pulse.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Terminal counts: half a bit to reach mid-start, a full bit between later samples.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_s;
    logic                  stop_good;

    Synchronizer #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Mid-stop-bit sample found the line high: the shift register holds a complete byte.
    assign stop_good = (state == STOP) && (cnt == FULL_LAST) && rx_s;

    // Receive FSM with bit timing, shift register, framing error and busy flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // Start bit did not persist to mid-bit: treat as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            // Byte is discarded; it is overwritten by the next frame.
                            framing_err <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A break holds the line low; only a return to idle re-arms the receiver.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer: load on a good stop bit when free or being drained, else flag overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_good) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks/bit, 8 data bits.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_uart_rx_ctrl;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       ready   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc      = 0;
    int vld_rise = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int rise_cyc = 0;
    int t0       = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] cap_q[$];

    uart_rx_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (valid && !valid_prev) begin
            vld_rise = vld_rise + 1;
            rise_cyc = cyc;
            cap_q.push_back(data);
        end
        valid_prev = valid;
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (overrun)     ov_cnt = ov_cnt + 1;
    end

    task automatic clear_counts();
        vld_rise = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        cap_q.delete();
    endtask

    // Called just after a falling edge; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clock);
        end
        rx = stop_bit;
        repeat (16) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        #1;
        checks++; if (data !== 8'h00)     begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", framing_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_good_frame();
        ready = 1'b1;
        @(negedge clock);
        clear_counts();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clock);
        checks++; if (vld_rise !== 1) begin errors++; $display("FAIL good_vld_count got %0d want 1", vld_rise); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0] !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", cap_q[0]); end
        end
        checks++; if ((rise_cyc - t0) < 150 || (rise_cyc - t0) > 156) begin
            errors++; $display("FAIL good_latency got %0d want 150..156", rise_cyc - t0);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_valid_after got %b want 0", valid); end
        checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++; $display("FAIL good_errs got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        int waited;
        @(negedge clock);
        clear_counts();
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_set got %b want 1", busy); end
        waited = 0;
        while (busy !== 1'b0 && waited < 12) begin
            @(negedge clock);
            waited++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear got %b want 0 within 12", busy); end
        repeat (20) @(negedge clock);
        checks++; if (vld_rise !== 0 || fe_cnt !== 0) begin
            errors++; $display("FAIL glitch_outputs got vld=%0d fe=%0d want 0 0", vld_rise, fe_cnt);
        end
    endtask

    task automatic test_framing();
        ready = 1'b1;
        @(negedge clock);
        clear_counts();
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clock);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_ferr_count got %0d want 1", fe_cnt); end
        checks++; if (vld_rise !== 0) begin errors++; $display("FAIL frame_valid got %0d want 0", vld_rise); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_break got %b want 1", busy); end
        rx = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_release got %b want 0", busy); end
        repeat (20) @(negedge clock);
        checks++; if (fe_cnt !== 1 || vld_rise !== 0) begin
            errors++; $display("FAIL frame_after got fe=%0d vld=%0d want 1 0", fe_cnt, vld_rise);
        end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        @(negedge clock);
        clear_counts();
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (valid !== 1'b1 || data !== 8'h11) begin
            errors++; $display("FAIL ovr_first got valid=%b data=%h want 1 11", valid, data);
        end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL ovr_early got %0d want 0", ov_cnt); end
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", ov_cnt); end
        checks++; if (data !== 8'h11 || valid !== 1'b1) begin
            errors++; $display("FAIL ovr_hold got valid=%b data=%h want 1 11", valid, data);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", valid); end
        checks++; if (vld_rise !== 1) begin errors++; $display("FAIL ovr_vld_count got %0d want 1", vld_rise); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h5A;
        ready = 1'b0;
        @(negedge clock);
        clear_counts();
        send_frame(8'h77, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", valid); end
        rx = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (16) @(negedge clock);
        end
        rx = b[3];
        repeat (8) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || data !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async got valid=%b data=%h busy=%b want 0 00 0", valid, data, busy);
        end
        checks++; if (framing_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rst_async_errs got fe=%b ov=%b want 0 0", framing_err, overrun);
        end
        repeat (3) @(negedge clock);
        rx      = 1'b1;
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checks++; if (fe_cnt !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_release got fe=%0d busy=%b want 0 0", fe_cnt, busy);
        end
        ready = 1'b1;
        clear_counts();
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (vld_rise !== 1) begin errors++; $display("FAIL rst_next_count got %0d want 1", vld_rise); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0] !== 8'h5A) begin errors++; $display("FAIL rst_next_data got %h want 5a", cap_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        @(negedge clock);
        clear_counts();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (vld_rise !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", vld_rise); end
        if (cap_q.size() > 1) begin
            checks++; if (cap_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", cap_q[0]); end
            checks++; if (cap_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", cap_q[1]); end
        end
        checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++; $display("FAIL b2b_errs got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clocks per serial bit time; legal values are 4 or more and even.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range is 5 to 9.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-006 Port data, output, DATA_BITS bits: received byte; first-received bit at bit 0.
REQ-007 Port valid, output, 1 bit: data holds an unconsumed byte.
REQ-008 Port ready, input, 1 bit: consumer accepts data on any edge where valid and ready are both high.
REQ-009 Port framing_err, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-011 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized signal (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: on rx_s==0 → START; clear the bit-time counter.
REQ-015 START: after CLKS_PER_BIT/2 clocks, sample rx_s. If 0 → DATA with counter and bit index cleared. If 1 → IDLE (glitch; no error flagged).
REQ-016 DATA: sample rx_s every CLKS_PER_BIT clocks (mid-bit) and shift it in LSB-first. After the DATA_BITS-th sample → STOP.
REQ-017 STOP: sample rx_s after CLKS_PER_BIT clocks. If 1, deliver the byte (REQ-019) and go to IDLE. If 0, pulse framing_err, discard the byte, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s==1, then go to IDLE; a line held low (break) SHALL NOT start a new frame.
REQ-019 Delivery:
- If valid==0, or valid&ready on the same edge: load data and set valid=1 on the next cycle.
- Otherwise: pulse overrun, drop the new byte; old data and valid are unchanged.
REQ-020 Once valid=1, data SHALL stay stable until the valid&ready edge; valid falls on the following cycle unless a simultaneous delivery reloads it.
REQ-021 Bit-time counter width SHALL be $clog2(CLKS_PER_BIT); bit index width SHALL be $clog2(DATA_BITS+1); no counter wraps in a legal frame.
REQ-022 A new start bit SHALL be accepted in the IDLE cycle immediately following STOP (back-to-back frames, no gap).

Reset
REQ-023 reset_n low SHALL immediately force: state=IDLE, data=0, valid=0, framing_err=0, overrun=0, busy=0, all counters=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the partial byte with no error pulse; reception resumes normally after release.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef and the default CLKS_PER_BIT and DATA_BITS constants.
REQ-026 The 2-flop synchronizer SHALL be the single sub-module, named Synchronizer, instantiated with reset derived from reset_n, flops presetting to line-idle.
REQ-027 Counters, shift register and output buffer SHALL be inline in uart_rx_ctrl.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-028 Frame 0xA5, ready=1 → valid pulses once with data=0xA5, 150..156 clocks after rx falls; no error pulses.
REQ-029 rx low for 4 clocks then high → no valid, no framing_err; busy returns to 0 within 12 clocks.
REQ-030 Frame 0x3C with stop bit 0, rx then held low 40 clocks → exactly one framing_err pulse; valid stays 0; busy stays 1 until rx is high.
REQ-031 Frames 0x11 then 0x22, ready=0 → data=0x11 and valid held; one overrun pulse at the second stop bit; data stays 0x11; ready=1 for one cycle → valid drops the next cycle.
REQ-032 reset_n pulsed low during DATA bit 3 → all outputs 0 without waiting for a clock edge; following frame 0x5A received correctly.
REQ-033 Back-to-back frames 0x00 then 0xFF with no idle gap, ready=1 → two valid pulses carrying 0x00 then 0xFF in order; no errors.
